// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler: shares one AXI-Stream master among NQ registered-output FIFO read ports.
// Optional build macro FIFO_RD_ARB_PKT_LOCK_EN keeps each queue's packet contiguous on m_axis.
module fifo_rd_arbiter #(
  parameter int NQ = 4,
  parameter int DW = 32,
  localparam int IDW = $clog2(NQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NQ-1:0]        i_empty,
  output logic [NQ-1:0]        o_ren,
  input  logic [NQ*DW-1:0]     i_rdata,
  input  logic [NQ-1:0]        i_rlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DW-1:0]        m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [IDW-1:0]       m_axis_tid,
  output logic                 o_busy
);

  logic [DW-1:0]  w_rdata [NQ];

  genvar gi;
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_unpack
      assign w_rdata[gi] = i_rdata[gi*DW +: DW];
    end
  endgenerate

  logic [IDW-1:0] r_last_grant;
  logic           r_inflight;
  logic [IDW-1:0] r_inflight_q;

  logic [DW-1:0]  r_buf_data [2];
  logic           r_buf_last [2];
  logic [IDW-1:0] r_buf_id   [2];
  logic           r_wr_ptr;
  logic           r_rd_ptr;
  logic [1:0]     r_count;

  logic           w_pop;
  logic           w_push;
  logic [2:0]     w_occ;
  logic           w_credit;
  logic [NQ-1:0]  w_elig;
  logic           w_grant_valid;
  logic [IDW-1:0] w_grant_q;
  logic           w_issue;

  assign w_pop    = (r_count != 2'd0) & m_axis_tready;
  assign w_push   = r_inflight;
  // Occupancy the buffer will reach once the in-flight beat lands, net of this cycle's pop.
  assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit = (w_occ < 3'd2);

`ifdef FIFO_RD_ARB_PKT_LOCK_EN
  localparam logic ST_ARB  = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  logic           r_state;
  logic [IDW-1:0] r_lock_q;
  logic           w_lock_active;
  logic [IDW-1:0] w_lock_q;

  // The beat being captured decides the lock this cycle, so no other queue slips in behind it.
  always_comb begin
    w_lock_active = 1'b0;
    w_lock_q      = r_lock_q;
    if (r_inflight) begin
      w_lock_active = ~i_rlast[r_inflight_q];
      w_lock_q      = r_inflight_q;
    end else begin
      w_lock_active = (r_state == ST_LOCK);
    end
  end

  always_comb begin
    w_elig = ~i_empty;
    if (w_lock_active) begin
      w_elig = ~i_empty & ({{(NQ-1){1'b0}}, 1'b1} << w_lock_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ARB;
      r_lock_q <= '0;
    end else if (w_push) begin
      r_state  <= i_rlast[r_inflight_q] ? ST_ARB : ST_LOCK;
      r_lock_q <= r_inflight_q;
    end
  end
`else
  assign w_elig = ~i_empty;
`endif

  always_comb begin
    logic [IDW:0] w_idx;
    w_grant_valid = 1'b0;
    w_grant_q     = '0;
    w_idx         = '0;
    for (int k = 1; k <= NQ; k++) begin
      w_idx = {1'b0, r_last_grant} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NQ)) begin
        w_idx = w_idx - (IDW+1)'(NQ);
      end
      if (!w_grant_valid && w_elig[w_idx[IDW-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_q     = w_idx[IDW-1:0];
      end
    end
  end

  assign w_issue = w_grant_valid & w_credit & ~rst;
  assign o_ren   = w_issue ? ({{(NQ-1){1'b0}}, 1'b1} << w_grant_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IDW'(NQ - 1);
      r_inflight   <= 1'b0;
      r_inflight_q <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
        r_buf_id[i]   <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_last_grant <= w_grant_q;
        r_inflight_q <= w_grant_q;
      end
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_rdata[r_inflight_q];
        r_buf_last[r_wr_ptr] <= i_rlast[r_inflight_q];
        r_buf_id[r_wr_ptr]   <= r_inflight_q;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign m_axis_tvalid = (r_count != 2'd0);
  assign m_axis_tdata  = r_buf_data[r_rd_ptr];
  assign m_axis_tlast  = r_buf_last[r_rd_ptr];
  assign m_axis_tid    = r_buf_id[r_rd_ptr];
  assign o_busy        = (r_count != 2'd0) | r_inflight;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: queue-based FIFO storage model plus a beat-level scoreboard.
module tb_fifo_rd_arbiter;
  localparam int NQ  = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NQ-1:0]     i_empty;
  logic [NQ-1:0]     o_ren;
  logic [NQ*DW-1:0]  i_rdata;
  logic [NQ-1:0]     i_rlast;
  logic              tvalid;
  logic              tready;
  logic [DW-1:0]     tdata;
  logic              tlast;
  logic [IDW-1:0]    tid;
  logic              busy;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(.NQ(NQ), .DW(DW)) dut (
    .clk(clk), .rst(rst), .i_empty(i_empty), .o_ren(o_ren),
    .i_rdata(i_rdata), .i_rlast(i_rlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .m_axis_tid(tid), .o_busy(busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            id;
  } beat_t;

  beat_t tbq [NQ][$];
  beat_t obuf[$];
  beat_t infl;
  bit    infl_v;
  int    lgrant;
  bit    lk_state;
  int    lk_q;

  int n_checks = 0;
  int n_fails  = 0;
  int hs_count = 0;
  int cyc      = 0;
  logic [NQ-1:0] ren_seen;
  int tid_log[$];
  int hs_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int q = 0; q < NQ; q++) i_empty[q] = (tbq[q].size() == 0);
  endtask

  task automatic push(input int q, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l; b.id = q;
    tbq[q].push_back(b);
    refresh();
  endtask

  function automatic bit idle();
    for (int q = 0; q < NQ; q++) if (tbq[q].size() != 0) return 0;
    return (obuf.size() == 0) && !infl_v;
  endfunction

  // Reference scheduler: credit rule, then first non-empty queue after the last grant.
  function automatic int exp_grant();
    int occ;
    bit lock_on;
    int lock_q;
    occ = obuf.size() + (infl_v ? 1 : 0) - ((obuf.size() > 0 && tready) ? 1 : 0);
    if (rst || occ >= 2) return -1;
    lock_on = 0;
    lock_q  = 0;
`ifdef FIFO_RD_ARB_PKT_LOCK_EN
    if (infl_v) begin
      lock_on = !infl.l;
      lock_q  = infl.id;
    end else begin
      lock_on = lk_state;
      lock_q  = lk_q;
    end
`endif
    for (int k = 1; k <= NQ; k++) begin
      int q;
      q = (lgrant + k) % NQ;
      if (tbq[q].size() > 0 && (!lock_on || q == lock_q)) return q;
    end
    return -1;
  endfunction

  task automatic tick();
    int g;
    logic [NQ-1:0] eren;
    @(negedge clk);
    g = exp_grant();
    eren = (g >= 0) ? (NQ'(1) << g) : '0;
    chk("ren", 64'(o_ren), 64'(eren));
    chk("tvalid", 64'(tvalid), 64'(obuf.size() != 0));
    chk("busy", 64'(busy), 64'((obuf.size() != 0) || infl_v));
    if (obuf.size() != 0) begin
      chk("tdata", 64'(tdata), 64'(obuf[0].d));
      chk("tlast", 64'(tlast), 64'(obuf[0].l));
      chk("tid", 64'(tid), 64'(obuf[0].id));
    end
    ren_seen = o_ren;
    if (tvalid && tready) begin
      hs_count++;
      tid_log.push_back(int'(tid));
      hs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      obuf.delete();
      infl_v   = 0;
      lgrant   = NQ - 1;
      lk_state = 0;
      lk_q     = 0;
    end else begin
      if (obuf.size() != 0 && tready) void'(obuf.pop_front());
      if (infl_v) begin
        obuf.push_back(infl);
        lk_state = !infl.l;
        lk_q     = infl.id;
      end
      infl_v = 0;
      if (g >= 0) begin
        infl = tbq[g].pop_front();
        infl_v = 1;
        lgrant = g;
        i_rdata[g*DW +: DW] = infl.d;
        i_rlast[g] = infl.l;
      end
    end
    refresh();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!idle() && n < 400) begin
      tick();
      n++;
    end
    chk("drain_busy", 64'(busy), 64'(0));
    chk("drain_tvalid", 64'(tvalid), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int reads;
    int base;
    rst = 1'b1; tready = 1'b0; i_empty = '1; i_rdata = '0; i_rlast = '0;
    obuf.delete(); infl_v = 0; lgrant = NQ - 1; lk_state = 0; lk_q = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_tid", 64'(tid), 64'(0));
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ren", 64'(o_ren), 64'(0));

    // All queues empty: nothing may move.
    repeat (20) tick();

    // Two beats per queue, continuous ready: strict rotation at one beat per cycle.
    tready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < NQ; q++) push(q, $urandom, 1'b1);
    tid_log.delete(); hs_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 30 && tid_log.size() < 8; i++) tick();
    chk("t2_beats", 64'(tid_log.size()), 64'(8));
    for (int i = 0; i < tid_log.size() && i < 8; i++) chk("t2_tid", 64'(tid_log[i]), 64'(i % NQ));
    if (hs_cyc.size() > 0) chk("t2_latency", 64'(hs_cyc[0] - c0), 64'(2));
    for (int i = 1; i < hs_cyc.size(); i++) chk("t2_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(1));
    drain();

    // Single non-empty queue is granted back to back.
    for (int i = 0; i < 5; i++) push(2, $urandom, 1'b1);
    tid_log.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_ren", 64'(ren_seen), 64'(4'b0100));
    end
    drain();
    chk("t3_beats", 64'(tid_log.size()), 64'(5));
    for (int i = 0; i < tid_log.size(); i++) chk("t3_tid", 64'(tid_log[i]), 64'(2));

    // Backpressure: only two reads may be issued, then nothing is lost on release.
    tready = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < NQ; q++) push(q, $urandom, 1'b1);
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ren_seen != '0) reads++;
    end
    chk("t4_reads", 64'(reads), 64'(2));
    base = hs_count;
    tready = 1'b1;
    drain();
    chk("t4_beats", 64'(hs_count - base), 64'(4 * NQ));

    // Reset with a beat buffered and a read in flight.
    tready = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < NQ; q++) push(q, $urandom, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_ren_in_rst", 64'(ren_seen), 64'(0));
    rst = 1'b0;
    chk("t5_tvalid", 64'(tvalid), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    tick();
    chk("t5_first_grant", 64'(ren_seen), 64'(4'b0001));
    tready = 1'b1;
    drain();

    // Random traffic, random ready, occasional reset.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        int q;
        q = $urandom_range(0, NQ - 1);
        if (tbq[q].size() < 6) push(q, $urandom, 1'($urandom_range(0, 1)));
      end
      tready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tready = 1'b1;
    for (int q = 0; q < NQ; q++) push(q, $urandom, 1'b1);
    drain();

`ifdef FIFO_RD_ARB_PKT_LOCK_EN
    // Packet lock: queue 0's three-beat packet completes before queue 1 is served.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(0, $urandom, 1'b0);
    push(0, $urandom, 1'b0);
    push(0, $urandom, 1'b1);
    push(1, $urandom, 1'b1);
    tid_log.delete();
    for (int i = 0; i < 30 && tid_log.size() < 4; i++) tick();
    chk("t7_beats", 64'(tid_log.size()), 64'(4));
    for (int i = 0; i < tid_log.size() && i < 4; i++)
      chk("t7_tid", 64'(tid_log[i]), 64'((i < 3) ? 0 : 1));
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
